// File: rtl/bin_minus_checker_if.sv
// Request/response bundle for the mixed-width subtract checker.
interface bin_minus_checker_if;
    localparam int unsigned WORDW  = 128;
    localparam int unsigned FIELDW = 4;

    logic              req_valid;
    logic              req_ready;
    logic [WORDW-1:0]  in_word;
    logic [WORDW-1:0]  out_word;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_pass;
    logic [FIELDW-1:0] rsp_field;
    logic              busy;

    modport master (
        output req_valid, in_word, out_word, rsp_ready,
        input  req_ready, rsp_valid, rsp_pass, rsp_field, busy
    );

    modport slave (
        input  req_valid, in_word, out_word, rsp_ready,
        output req_ready, rsp_valid, rsp_pass, rsp_field, busy
    );
endinterface

// File: rtl/bin_minus_checker.sv
// Add-back checker for the packed mixed-width subtract vector: walks ten
// result fields plus the zero pad, one per cycle, and reports the first miss.
module bin_minus_checker (
    input  logic               clk,
    input  logic               rst_n,
    bin_minus_checker_if.slave bus
);
    localparam int unsigned NFIELDS = 11;
    localparam int unsigned STEPW   = 4;
    localparam int unsigned OPW     = 31;
    localparam int unsigned WORDW   = 128;
    localparam int unsigned ACCW    = 16;
    localparam logic [STEPW-1:0] LAST_STEP = STEPW'(NFIELDS - 1);
    localparam logic [3:0]       NO_FAIL   = 4'hF;

    typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

    state_t             state_q, state_d;
    logic [STEPW-1:0]   step_q, step_d;
    logic               pass_q, pass_d;
    logic [OPW-1:0]     op_q;
    logic [WORDW-1:0]   res_q;
    logic               capture;
    logic [3:0]         field_d;
    logic               rsp_pass_d;
    logic [ACCW-1:0]    opnd, addend, target, mask, sum;
    logic               step_ok;
    logic               unused_in;

    // Only the low 31 operand bits carry fields.
    assign unused_in = ^bus.in_word[WORDW-1:OPW];

    logic [1:0] b2;
    logic [5:0] b6;
    logic [8:0] b9, a9;
    logic       a1;
    logic [3:0] a4;
    assign b2 = op_q[1:0];
    assign b6 = op_q[7:2];
    assign b9 = op_q[16:8];
    assign a1 = op_q[17];
    assign a4 = op_q[21:18];
    assign a9 = op_q[30:22];

    // Per-step operand selection with the extension each field expects.
    always_comb begin
        opnd   = '0;
        addend = '0;
        target = '0;
        mask   = '0;
        case (step_q)
            4'd0: begin opnd = ACCW'(res_q[8:0]);   addend = ACCW'(b9);          target = ACCW'(a9);          mask = 16'h01FF; end
            4'd1: begin opnd = ACCW'(res_q[12:9]);  addend = ACCW'(b6);          target = ACCW'(a4);          mask = 16'h000F; end
            4'd2: begin opnd = ACCW'(res_q[13]);    addend = ACCW'(b2[0]);       target = ACCW'(a1);          mask = 16'h0001; end
            4'd3: begin opnd = res_q[29:14];        addend = ACCW'(b6);          target = ACCW'(a9);          mask = 16'hFFFF; end
            4'd4: begin opnd = ACCW'(res_q[36:30]); addend = ACCW'(b9);          target = ACCW'(a9);          mask = 16'h007F; end
            4'd5: begin opnd = ACCW'(res_q[45:37]); addend = ACCW'(b9);          target = ACCW'(a9);          mask = 16'h01FF; end
            4'd6: begin opnd = ACCW'(res_q[49:46]); addend = {{10{b6[5]}}, b6}; target = {{12{a4[3]}}, a4}; mask = 16'h000F; end
            4'd7: begin opnd = ACCW'(res_q[50]);    addend = ACCW'(b2[0]);       target = ACCW'(a1);          mask = 16'h0001; end
            4'd8: begin opnd = res_q[66:51];        addend = {{10{b6[5]}}, b6}; target = {{7{a9[8]}}, a9};   mask = 16'hFFFF; end
            4'd9: begin opnd = ACCW'(res_q[73:67]); addend = {{14{b2[1]}}, b2}; target = ACCW'(a9);          mask = 16'h007F; end
            default: ;
        endcase
    end

    assign sum     = opnd + addend;
    assign step_ok = (step_q == LAST_STEP) ? (res_q[WORDW-1:74] == '0)
                                           : (((sum ^ target) & mask) == '0);

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        pass_d     = pass_q;
        field_d    = bus.rsp_field;
        rsp_pass_d = bus.rsp_pass;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    capture    = 1'b1;
                    step_d     = '0;
                    pass_d     = 1'b1;
                    field_d    = NO_FAIL;
                    rsp_pass_d = 1'b0;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                // Only the first miss records its index.
                if (!step_ok && pass_q) begin
                    pass_d  = 1'b0;
                    field_d = step_q;
                end
                if (step_q == LAST_STEP) begin
                    rsp_pass_d = pass_q && step_ok;
                    state_d    = REPORT;
                end else begin
                    step_d = step_q + STEPW'(1);
                end
            end
            REPORT: begin
                if (bus.rsp_valid && bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            step_q        <= '0;
            pass_q        <= 1'b1;
            op_q          <= '0;
            res_q         <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_pass  <= 1'b0;
            bus.rsp_field <= NO_FAIL;
            bus.busy      <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            pass_q        <= pass_d;
            if (capture) begin
                op_q  <= bus.in_word[OPW-1:0];
                res_q <= bus.out_word;
            end
            bus.req_ready <= (state_d == IDLE);
            bus.rsp_valid <= (state_d == REPORT);
            bus.rsp_pass  <= rsp_pass_d;
            bus.rsp_field <= field_d;
            bus.busy      <= (state_d != IDLE);
        end
    end
endmodule
